// File: rtl/sbit_rate_monitor.sv
// Masks and registers the aligned 24-VFAT S-bit bus and measures per-VFAT active-cycle
// rates over a programmable gate window, with snapshots readable through a select port.
module sbit_rate_monitor #(
    parameter int unsigned DDR        = 0,
    parameter int unsigned MXSBITS    = 64 + 64 * DDR,
    parameter int unsigned MXVFATS    = 24,
    parameter int unsigned CNT_WIDTH  = 16,
    parameter int unsigned GATE_WIDTH = 24
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic [MXSBITS*MXVFATS-1:0]   sbits_in,
    input  logic [MXVFATS-1:0]           vfat_mask,
    input  logic [GATE_WIDTH-1:0]        gate_length,
    input  logic [4:0]                   rate_sel,
    output logic [MXSBITS*MXVFATS-1:0]   sbits_out,
    output logic [MXVFATS-1:0]           vfat_active,
    output logic [CNT_WIDTH-1:0]         rate_out,
    output logic                         rate_valid,
    output logic [GATE_WIDTH-1:0]        window_count
);

    // Counter index MXVFATS holds the OR-of-all rate.
    localparam int unsigned          NCNT    = MXVFATS + 1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                       state, state_next;
    logic                         enable_c, close_c, last_c;
    logic [MXSBITS*MXVFATS-1:0]   masked_c;
    logic [MXVFATS-1:0]           active_c;
    logic [NCNT-1:0]              hit_c;
    logic [CNT_WIDTH-1:0]         live [NCNT];
    logic [CNT_WIDTH-1:0]         snap [NCNT];
    logic [CNT_WIDTH-1:0]         sum_c [NCNT];
    logic [CNT_WIDTH-1:0]         rate_mux_c;

    // Stage 1: per-VFAT mask and activity OR.
    always_comb begin
        masked_c = '0;
        active_c = '0;
        for (int unsigned k = 0; k < MXVFATS; k++) begin
            masked_c[k*MXSBITS +: MXSBITS] = vfat_mask[k] ? '0 : sbits_in[k*MXSBITS +: MXSBITS];
            active_c[k] = ~vfat_mask[k] & (|sbits_in[k*MXSBITS +: MXSBITS]);
        end
    end

    assign hit_c  = {|vfat_active, vfat_active};
    assign last_c = (window_count >= (gate_length - GATE_WIDTH'(1)));

    // Saturating next value of every live counter, including this cycle's hit.
    always_comb begin
        for (int unsigned i = 0; i < NCNT; i++) begin
            sum_c[i] = (live[i] == CNT_MAX) ? CNT_MAX : live[i] + CNT_WIDTH'(hit_c[i]);
        end
    end

    always_comb begin
        rate_mux_c = '0;
        for (int unsigned i = 0; i < NCNT; i++) begin
            if (rate_sel == 5'(i)) begin
                rate_mux_c = snap[i];
            end
        end
    end

    // Window FSM: the first cycle with a nonzero gate is already window cycle 0.
    always_comb begin
        state_next = state;
        enable_c   = 1'b0;
        close_c    = 1'b0;
        case (state)
            IDLE: begin
                if (gate_length != '0) begin
                    state_next = RUN;
                    enable_c   = 1'b1;
                    close_c    = last_c;
                end
            end
            RUN: begin
                if (gate_length == '0) begin
                    state_next = IDLE;
                end else begin
                    enable_c = 1'b1;
                    close_c  = last_c;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sbits_out    <= '0;
            vfat_active  <= '0;
            rate_out     <= '0;
            rate_valid   <= 1'b0;
            window_count <= '0;
            for (int unsigned i = 0; i < NCNT; i++) begin
                live[i] <= '0;
                snap[i] <= '0;
            end
        end else begin
            sbits_out   <= masked_c;
            vfat_active <= active_c;
            rate_valid  <= close_c;
            rate_out    <= rate_mux_c;
            if (!enable_c) begin
                window_count <= '0;
                for (int unsigned i = 0; i < NCNT; i++) begin
                    live[i] <= '0;
                end
            end else if (close_c) begin
                window_count <= '0;
                for (int unsigned i = 0; i < NCNT; i++) begin
                    live[i] <= '0;
                    snap[i] <= sum_c[i];
                end
            end else begin
                window_count <= window_count + GATE_WIDTH'(1);
                for (int unsigned i = 0; i < NCNT; i++) begin
                    live[i] <= sum_c[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_sbit_rate_monitor.sv
// Directed bench for sbit_rate_monitor: reset, rate measurement, masking, saturation,
// gate boundaries, and disable/reset in the middle of a window.
module tb_sbit_rate_monitor;

    localparam int unsigned MXSBITS    = 64;
    localparam int unsigned MXVFATS    = 24;
    localparam int unsigned CNT_WIDTH  = 16;
    localparam int unsigned GATE_WIDTH = 24;
    localparam int unsigned SW         = MXSBITS * MXVFATS;

    logic                  clock = 1'b0;
    logic                  reset_n = 1'b0;
    logic [SW-1:0]         sbits_in = '0;
    logic [MXVFATS-1:0]    vfat_mask = '0;
    logic [GATE_WIDTH-1:0] gate_length = '0;
    logic [4:0]            rate_sel = '0;
    logic [SW-1:0]         sbits_out;
    logic [MXVFATS-1:0]    vfat_active;
    logic [CNT_WIDTH-1:0]  rate_out;
    logic                  rate_valid;
    logic [GATE_WIDTH-1:0] window_count;

    // Narrow-counter instance so saturation is reachable in a short run.
    logic [SW-1:0]         sbits_out_s;
    logic [MXVFATS-1:0]    vfat_active_s;
    logic [7:0]            rate_out_s;
    logic                  rate_valid_s;
    logic [GATE_WIDTH-1:0] window_count_s;

    int errors = 0;
    int checks = 0;

    sbit_rate_monitor #(.DDR(0), .MXVFATS(MXVFATS), .CNT_WIDTH(CNT_WIDTH), .GATE_WIDTH(GATE_WIDTH)) dut (
        .clock(clock), .reset_n(reset_n), .sbits_in(sbits_in), .vfat_mask(vfat_mask),
        .gate_length(gate_length), .rate_sel(rate_sel), .sbits_out(sbits_out),
        .vfat_active(vfat_active), .rate_out(rate_out), .rate_valid(rate_valid),
        .window_count(window_count)
    );

    sbit_rate_monitor #(.DDR(0), .MXVFATS(MXVFATS), .CNT_WIDTH(8), .GATE_WIDTH(GATE_WIDTH)) dut_s (
        .clock(clock), .reset_n(reset_n), .sbits_in(sbits_in), .vfat_mask(vfat_mask),
        .gate_length(gate_length), .rate_sel(rate_sel), .sbits_out(sbits_out_s),
        .vfat_active(vfat_active_s), .rate_out(rate_out_s), .rate_valid(rate_valid_s),
        .window_count(window_count_s)
    );

    always #5 clock = ~clock;

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    function automatic logic [SW-1:0] sbit(input int unsigned vfat, input int unsigned b);
        logic [SW-1:0] v;
        v = '0;
        v[vfat*MXSBITS+b] = 1'b1;
        return v;
    endfunction

    task automatic wait_valid(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            step();
            if (rate_valid === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        bit bad_valid, bad_wc;
        reset_n = 1'b0;
        for (int c = 0; c < 5; c++) begin
            for (int w = 0; w < int'(SW / 32); w++) sbits_in[w*32 +: 32] = $urandom;
            step();
        end
        checks++; if (sbits_out !== '0) begin errors++; $display("FAIL reset_sbits_out: nonzero while in reset, expected 0"); end
        checks++; if (vfat_active !== '0) begin errors++; $display("FAIL reset_vfat_active: got %h expected 0", vfat_active); end
        checks++; if (rate_out !== '0) begin errors++; $display("FAIL reset_rate_out: got %0d expected 0", rate_out); end
        checks++; if (rate_valid !== 1'b0) begin errors++; $display("FAIL reset_rate_valid: got %b expected 0", rate_valid); end
        checks++; if (window_count !== '0) begin errors++; $display("FAIL reset_window_count: got %0d expected 0", window_count); end
        sbits_in = '0;
        gate_length = '0;
        reset_n = 1'b1;
        bad_valid = 1'b0;
        bad_wc = 1'b0;
        repeat (100) begin
            step();
            if (rate_valid !== 1'b0) bad_valid = 1'b1;
            if (window_count !== '0) bad_wc = 1'b1;
        end
        checks++; if (bad_valid) begin errors++; $display("FAIL idle_rate_valid: pulsed with gate 0, expected none"); end
        checks++; if (bad_wc) begin errors++; $display("FAIL idle_window_count: moved with gate 0, expected 0"); end
    endtask

    task automatic test_basic_rate();
        bit seen;
        sbits_in = '0; gate_length = '0; step(2);
        gate_length = 24'd100;
        sbits_in = sbit(3, 5);
        step();
        checks++; if (window_count !== 24'd1) begin errors++; $display("FAIL basic_wc_start: got %0d expected 1", window_count); end
        checks++; if (sbits_out !== sbit(3, 5)) begin errors++; $display("FAIL basic_sbits_out: slice 3 bit 5 not passed through"); end
        checks++; if (vfat_active !== 24'h000008) begin errors++; $display("FAIL basic_vfat_active: got %h expected 000008", vfat_active); end
        step(39);
        sbits_in = '0;
        wait_valid(200, seen);
        checks++; if (!seen) begin errors++; $display("FAIL basic_rate_valid: no pulse, expected one"); end
        checks++; if (window_count !== '0) begin errors++; $display("FAIL basic_wc_at_pulse: got %0d expected 0", window_count); end
        step();
        checks++; if (rate_valid !== 1'b0) begin errors++; $display("FAIL basic_pulse_width: rate_valid=%b expected 0", rate_valid); end
        rate_sel = 5'd3; step();
        checks++; if (rate_out !== 16'd40) begin errors++; $display("FAIL basic_sel3: got %0d expected 40", rate_out); end
        rate_sel = 5'd24; step();
        checks++; if (rate_out !== 16'd40) begin errors++; $display("FAIL basic_sel24: got %0d expected 40", rate_out); end
        rate_sel = 5'd4; step();
        checks++; if (rate_out !== 16'd0) begin errors++; $display("FAIL basic_sel4: got %0d expected 0", rate_out); end
        rate_sel = 5'd30; step();
        checks++; if (rate_out !== 16'd0) begin errors++; $display("FAIL basic_sel30: got %0d expected 0", rate_out); end
    endtask

    task automatic test_masking();
        bit seen;
        gate_length = '0; sbits_in = '0; step(2);
        vfat_mask = 24'h000008;
        sbits_in = sbit(3, 5) | sbit(10, 63);
        step();
        checks++; if (sbits_out !== sbit(10, 63)) begin errors++; $display("FAIL mask_sbits_out: slice 3 not zeroed or slice 10 lost"); end
        checks++; if (vfat_active !== 24'h000400) begin errors++; $display("FAIL mask_vfat_active: got %h expected 000400", vfat_active); end
        sbits_in = '0; step(2);
        gate_length = 24'd100;
        sbits_in = sbit(3, 5);
        step(40);
        checks++; if (vfat_active !== '0) begin errors++; $display("FAIL mask_active_run: got %h expected 0", vfat_active); end
        sbits_in = '0;
        wait_valid(200, seen);
        checks++; if (!seen) begin errors++; $display("FAIL mask_rate_valid: no pulse, expected one"); end
        rate_sel = 5'd3; step();
        checks++; if (rate_out !== 16'd0) begin errors++; $display("FAIL mask_sel3: got %0d expected 0", rate_out); end
        rate_sel = 5'd24; step();
        checks++; if (rate_out !== 16'd0) begin errors++; $display("FAIL mask_sel24: got %0d expected 0", rate_out); end
        vfat_mask = '0;
    endtask

    task automatic test_saturation();
        gate_length = '0; sbits_in = sbit(0, 0); step(3);
        gate_length = 24'd100000;
        step(300);
        checks++; if (window_count !== 24'd300) begin errors++; $display("FAIL sat_wc: got %0d expected 300", window_count); end
        gate_length = 24'd1;
        step();
        checks++; if (rate_valid_s !== 1'b1) begin errors++; $display("FAIL sat_valid_narrow: got %b expected 1", rate_valid_s); end
        checks++; if (rate_valid !== 1'b1) begin errors++; $display("FAIL sat_valid_wide: got %b expected 1", rate_valid); end
        gate_length = '0; sbits_in = '0; rate_sel = 5'd0; step();
        checks++; if (rate_out_s !== 8'd255) begin errors++; $display("FAIL sat_narrow_sel0: got %0d expected 255", rate_out_s); end
        checks++; if (rate_out !== 16'd301) begin errors++; $display("FAIL sat_wide_sel0: got %0d expected 301", rate_out); end
        rate_sel = 5'd24; step();
        checks++; if (rate_out_s !== 8'd255) begin errors++; $display("FAIL sat_narrow_sel24: got %0d expected 255", rate_out_s); end
        checks++; if (rate_out !== 16'd301) begin errors++; $display("FAIL sat_wide_sel24: got %0d expected 301", rate_out); end
    endtask

    task automatic test_gate_one();
        logic [15:0] d [16];
        gate_length = '0; sbits_in = '0; step(3);
        rate_sel = 5'd7;
        gate_length = 24'd1;
        for (int c = 0; c < 16; c++) begin
            d[c] = (c % 2 == 0) ? 16'd1 : 16'd0;
            sbits_in = (c % 2 == 0) ? sbit(7, 0) : '0;
            step();
            checks++; if (rate_valid !== 1'b1) begin errors++; $display("FAIL gate1_valid_c%0d: got %b expected 1", c, rate_valid); end
            if (c >= 2) begin
                checks++; if (rate_out !== d[c-2]) begin errors++; $display("FAIL gate1_rate_c%0d: got %0d expected %0d", c, rate_out, d[c-2]); end
            end
        end
    endtask

    task automatic test_shrink();
        bit early;
        gate_length = '0; sbits_in = sbit(7, 0); step(3);
        gate_length = 24'd1000;
        early = 1'b0;
        repeat (500) begin
            step();
            if (rate_valid !== 1'b0) early = 1'b1;
        end
        checks++; if (early) begin errors++; $display("FAIL shrink_early: pulse before count 500, expected none"); end
        checks++; if (window_count !== 24'd500) begin errors++; $display("FAIL shrink_wc: got %0d expected 500", window_count); end
        gate_length = 24'd10;
        step();
        checks++; if (rate_valid !== 1'b1) begin errors++; $display("FAIL shrink_valid: got %b expected 1", rate_valid); end
        checks++; if (window_count !== '0) begin errors++; $display("FAIL shrink_wc_reload: got %0d expected 0", window_count); end
        gate_length = '0; rate_sel = 5'd7; step();
        checks++; if (rate_out !== 16'd501) begin errors++; $display("FAIL shrink_snapshot: got %0d expected 501", rate_out); end
        sbits_in = '0;
    endtask

    task automatic test_disable();
        bit bad;
        gate_length = '0; sbits_in = sbit(7, 0); step(2);
        gate_length = 24'd200;
        step(150);
        checks++; if (window_count !== 24'd150) begin errors++; $display("FAIL dis_wc: got %0d expected 150", window_count); end
        gate_length = '0;
        step();
        checks++; if (window_count !== '0) begin errors++; $display("FAIL dis_wc_idle: got %0d expected 0", window_count); end
        bad = 1'b0;
        repeat (60) begin
            step();
            if (rate_valid !== 1'b0) bad = 1'b1;
        end
        checks++; if (bad) begin errors++; $display("FAIL dis_no_pulse: rate_valid pulsed, expected none"); end
        rate_sel = 5'd7; step();
        checks++; if (rate_out !== 16'd501) begin errors++; $display("FAIL dis_keep_sel7: got %0d expected 501", rate_out); end
        rate_sel = 5'd24; step();
        checks++; if (rate_out !== 16'd501) begin errors++; $display("FAIL dis_keep_sel24: got %0d expected 501", rate_out); end
    endtask

    task automatic test_reset_mid();
        bit bad;
        gate_length = 24'd200;
        step(150);
        checks++; if (window_count !== 24'd150) begin errors++; $display("FAIL rstmid_wc: got %0d expected 150", window_count); end
        reset_n = 1'b0;
        #2;
        checks++; if (window_count !== '0) begin errors++; $display("FAIL rstmid_async_wc: got %0d expected 0", window_count); end
        checks++; if (vfat_active !== '0) begin errors++; $display("FAIL rstmid_async_active: got %h expected 0", vfat_active); end
        step(2);
        reset_n = 1'b1;
        bad = 1'b0;
        repeat (20) begin
            step();
            if (rate_valid !== 1'b0) bad = 1'b1;
        end
        checks++; if (bad) begin errors++; $display("FAIL rstmid_no_pulse: rate_valid pulsed after release, expected none"); end
        rate_sel = 5'd7; step();
        checks++; if (rate_out !== 16'd0) begin errors++; $display("FAIL rstmid_sel7: got %0d expected 0", rate_out); end
        rate_sel = 5'd24; step();
        checks++; if (rate_out !== 16'd0) begin errors++; $display("FAIL rstmid_sel24: got %0d expected 0", rate_out); end
        rate_sel = 5'd0; step();
        checks++; if (rate_out !== 16'd0) begin errors++; $display("FAIL rstmid_sel0: got %0d expected 0", rate_out); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic_rate();
        test_masking();
        test_saturation();
        test_gate_one();
        test_shrink();
        test_disable();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
